// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch and IF/ID.
// Circular buffer with first-word-fall-through head and flush accounting.
module inst_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_instruction,
    input  logic [WIDTH-1:0]           in_PC_plus_two,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_instruction,
    output logic [WIDTH-1:0]           out_PC_plus_two,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem_ins [DEPTH];
    logic [WIDTH-1:0] r_mem_pc  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_drop;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [8:0]       w_drop_sum;

    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count < FULL) && !flush && !rst;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    // Empty queue shows a NOP bubble, never stale storage.
    assign out_instruction = w_empty ? '0 : r_mem_ins[r_rd_ptr];
    assign out_PC_plus_two = w_empty ? '0 : r_mem_pc[r_rd_ptr];

    assign count      = r_count;
    assign drop_count = r_drop;
    assign w_drop_sum = {1'b0, r_drop} + 9'(r_count);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ins[r_wr_ptr] <= in_instruction;
            r_mem_pc[r_wr_ptr]  <= in_PC_plus_two;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Scoreboard bench for inst_prefetch_queue: directed stimulus pushes
// expected entries, a negedge monitor checks each popped head in order.
module tb_inst_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_instruction = '0;
    logic [15:0] in_PC_plus_two = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instruction;
    logic [15:0] out_PC_plus_two;
    logic [2:0]  count;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    inst_prefetch_queue #(.DEPTH(4), .WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_instruction (in_instruction),
        .in_PC_plus_two (in_PC_plus_two),
        .in_ready       (in_ready),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_PC_plus_two(out_PC_plus_two),
        .count          (count),
        .drop_count     (drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge, so compare the head now.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {out_instruction, out_PC_plus_two},
                    32'hDEAD_BEEF);
            end else begin
                chk("pop_data", {out_instruction, out_PC_plus_two},
                    exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [15:0] ins, input logic [15:0] pc,
                              input bit accepted);
        in_valid       = 1'b1;
        in_instruction = ins;
        in_PC_plus_two = pc;
        if (accepted) exp_q.push_back({ins, pc});
    endtask

    task automatic idle_in();
        in_valid       = 1'b0;
        in_instruction = '0;
        in_PC_plus_two = '0;
    endtask

    initial begin
        // Reset
        tick();
        chk("ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        chk("valid_after_rst", 32'(out_valid), 32'd0);
        chk("count_after_rst", 32'(count), 32'd0);
        chk("data_after_rst", {out_instruction, out_PC_plus_two}, 32'd0);
        chk("drop_after_rst", 32'(drop_count), 32'd0);

        // Single push, FWFT visible next cycle
        drive_push(16'h1234, 16'h0002, 1'b1);
        tick();
        idle_in();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", {out_instruction, out_PC_plus_two}, 32'h1234_0002);
        chk("first_count", 32'(count), 32'd1);

        // Fill with decode stalled
        drive_push(16'hB000, 16'h0004, 1'b1);
        tick();
        chk("hold_b", 32'(out_instruction), 32'h1234);
        drive_push(16'hC000, 16'h0006, 1'b1);
        tick();
        chk("hold_c", 32'(out_instruction), 32'h1234);
        drive_push(16'hD000, 16'h0008, 1'b1);
        tick();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        drive_push(16'hE000, 16'h000A, 1'b0);
        tick();
        idle_in();
        chk("fifth_rejected", 32'(count), 32'd4);
        chk("hold_full", 32'(out_instruction), 32'h1234);

        // Drain
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_data", {out_instruction, out_PC_plus_two}, 32'd0);
        out_ready = 1'b0;

        // Pointer wrap with sustained push+pop at count 2
        drive_push(16'h2000, 16'h0100, 1'b1);
        tick();
        drive_push(16'h2001, 16'h0102, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_push(16'h3000 + 16'(i), 16'h0200 + 16'(2 * i), 1'b1);
            tick();
            chk("wrap_count", 32'(count), 32'd2);
        end
        idle_in();
        repeat (2) tick();
        chk("wrap_drained", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush at count 3 with push and pop requested
        for (int i = 0; i < 3; i++) begin
            drive_push(16'h4000 + 16'(i), 16'h0300, 1'b1);
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        drive_push(16'h4FFF, 16'h0FFF, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        #1;
        chk("ready_in_flush", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        idle_in();
        out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", {out_instruction, out_PC_plus_two}, 32'd0);
        chk("flush_drop", 32'(drop_count), 32'd3);

        // Flush on empty queue
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush_drop", 32'(drop_count), 32'd3);

        // Saturation: 90 flushes of 3 entries
        for (int i = 0; i < 90; i++) begin
            for (int j = 0; j < 3; j++) begin
                drive_push(16'h5000 + 16'(j), 16'h0400, 1'b1);
                tick();
            end
            idle_in();
            flush = 1'b1;
            exp_q.delete();
            tick();
            flush = 1'b0;
            if (i == 39) chk("drop_mid", 32'(drop_count), 32'd123);
        end
        chk("drop_sat", 32'(drop_count), 32'd255);

        // Reset mid-operation beats flush
        drive_push(16'h6000, 16'h0500, 1'b1);
        tick();
        drive_push(16'h6001, 16'h0502, 1'b1);
        tick();
        idle_in();
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_data", 32'(out_instruction), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Final push/pop and scoreboard drain
        drive_push(16'h7ABC, 16'h0600, 1'b1);
        tick();
        idle_in();
        out_ready = 1'b1;
        repeat (2) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 The module SHALL have one parameter, DEPTH: default 4; the number of queue entries, a power of two, minimum 2.
REQ-002 The module SHALL have one parameter, WIDTH: default 16; the width of the instruction and PC fields.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  Fetch presents an instruction this cycle.
REQ-007 Port in_instruction  input  WIDTH  fetched instruction.
REQ-008 Port in_PC_plus_two  input  WIDTH  PC+2 of the fetched instruction.
REQ-009 Port in_ready  output  1  queue accepts a push this cycle.
REQ-010 Port flush  input  1  taken branch (PC_Src); discard all queued entries.
REQ-011 Port out_valid  output  1  head entry is available to IF/ID.
REQ-012 Port out_ready  input  1  IF/ID consumes the head this cycle (deasserted = decode stall).
REQ-013 Port out_instruction  output  WIDTH  head instruction.
REQ-014 Port out_PC_plus_two  output  WIDTH  head PC+2.
REQ-015 Port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 Port drop_count  output  8  saturating count of entries discarded by flushes.

Function
REQ-017 The queue SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits, each wrapping modulo DEPTH.
REQ-018 A push SHALL occur when in_valid=1, in_ready=1 and flush=0; it writes {in_instruction, in_PC_plus_two} at the write pointer, and the write pointer then increments.
REQ-019 A pop SHALL occur when out_valid=1, out_ready=1 and flush=0; the read pointer then increments.
REQ-020 in_ready SHALL equal (count<DEPTH) AND NOT flush AND NOT rst, decoded combinationally; there SHALL be no push into a full queue, even when a pop occurs in the same cycle.
REQ-021 out_valid SHALL equal (count!=0); the head is shown first-word-fall-through from storage.
REQ-022 When count=0, out_instruction and out_PC_plus_two SHALL be 0 (a NOP bubble).
REQ-023 Latency: an entry pushed into an empty queue at edge N SHALL be visible with out_valid=1 in the cycle after edge N.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 A push alone SHALL increment count; a pop alone SHALL decrement count.
REQ-026 Entries SHALL emerge in push order and each entry SHALL emerge exactly once.
REQ-027 flush=1 at an edge SHALL set count to 0 and both pointers to 0, and SHALL suppress any push or pop in that cycle.
REQ-028 On flush, drop_count SHALL add the pre-flush count and saturate at 255.
REQ-029 When flush=1 and count=0, drop_count SHALL be unchanged.
REQ-030 When out_ready=0 and out_valid=1, the head data SHALL be held stable until it is popped or flushed.

Reset
REQ-031 When rst=1 at an edge, the module SHALL clear the pointers, count and drop_count to 0.
REQ-032 After reset, out_valid SHALL be 0 and the outputs SHALL be 0.
REQ-033 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-034 rst SHALL take priority over flush, push and pop.
REQ-035 Storage contents need not be cleared by reset, but SHALL never be visible while count=0.

Verification
REQ-036 Reset then idle: push 0x1234/PC 0x0002 -> next cycle out_valid=1, out_instruction=0x1234, out_PC_plus_two=0x0002, count=1.
REQ-037 Fill with out_ready=0: push A,B,C,D -> count=4, in_ready=0; a fifth in_valid is not accepted; out_instruction stays A.
REQ-038 Pointer wrap: sustain push and pop together for 10 cycles at count=2 -> count stays 2, output order equals input order across wrap.
REQ-039 Flush at count=3 with in_valid=1 and out_ready=1 in the same cycle -> count=0, out_valid=0, drop_count=3, nothing pushed or popped.
REQ-040 drop_count saturation: 90 flushes at count=3 -> drop_count=255, with no wrap to a small value.
REQ-041 Reset mid-operation at count=2 with flush=1 -> count=0, drop_count=0, out_instruction=0x0000, in_ready=1 the next cycle.
